// File: rtl/rv32i_types.sv
// Shared types for the CDB arbiter slice: broadcast entry layout, FU indices
// and a small wrap-around helper used by the round-robin selector.
package rv32i_types;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 3;

  // Producer indices on the arbiter's fu_* vectors.
  localparam int FU_ALU = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;

  // One result as it travels from an FU to the common data bus.
  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob;
    logic [XLEN-1:0]      data;
  } cdb_entry_t;

  // Next index in a ring of n slots.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_fu_fifo.sv
// Single-FU result FIFO. A push into a full FIFO is accepted only when a pop
// happens at the same edge; otherwise it is ignored (the parent flags it).
// Flush empties the FIFO synchronously.
module cdb_fu_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 35
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   enq,
  input  logic [W-1:0]           enq_data,
  input  logic                   deq,
  output logic [W-1:0]           head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic          w_do_deq;
  logic          w_do_enq;

  assign empty    = (r_cnt == '0);
  assign full     = (r_cnt == (AW+1)'(DEPTH));
  assign count    = r_cnt;
  assign head     = r_mem[r_rd];
  assign w_do_deq = deq & ~empty;
  assign w_do_enq = enq & (~full | w_do_deq);

  // Storage array; contents only matter where the pointers say they do.
  always_ff @(posedge clk) begin
    if (w_do_enq && !flush) r_mem[r_wr] <= enq_data;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_enq) r_wr <= r_wr + AW'(1);
      if (w_do_deq) r_rd <= r_rd + AW'(1);
      case ({w_do_enq, w_do_deq})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers one-cycle FU completion pulses in per-FU
// FIFOs and broadcasts up to CDB_SIZE of them per cycle, round-robin.
// Optional macro CDB_ARB_BYPASS_EN lets a result arriving at an empty FIFO
// compete for a lane in its own cycle (one-cycle latency).
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int N_FU       = 3,
  parameter int CDB_SIZE   = 2,
  parameter int ROB_DEPTH  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [N_FU-1:0]                     fu_valid,
  input  logic [N_FU-1:0][ROB_DEPTH-1:0]      fu_rob,
  input  logic [N_FU-1:0][31:0]               fu_data,
  output logic [N_FU-1:0]                     fu_stall,
  output logic [CDB_SIZE-1:0]                 cdb_valid,
  output logic [CDB_SIZE-1:0][ROB_DEPTH-1:0]  cdb_rob,
  output logic [CDB_SIZE-1:0][31:0]           cdb_rd_v,
  output logic                                overflow_err
);

  localparam int EW = ROB_DEPTH + 32;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [EW-1:0]       w_in_entry [N_FU];
  logic [EW-1:0]       w_head     [N_FU];
  logic [CW-1:0]       w_count    [N_FU];
  logic [N_FU-1:0]     w_empty;
  logic [N_FU-1:0]     w_full;
  logic [N_FU-1:0]     w_grant;
  logic [N_FU-1:0]     w_deq;
  logic [N_FU-1:0]     w_enq;
  logic [N_FU-1:0]     w_ovf;
  logic [CDB_SIZE-1:0] w_lane_v;
  logic [EW-1:0]       w_lane_e [CDB_SIZE];
  logic                w_any;
  logic [PW-1:0]       w_last;

  logic [PW-1:0]                     r_rr_ptr;
  logic [CDB_SIZE-1:0]               r_cdb_valid;
  logic [CDB_SIZE-1:0][ROB_DEPTH-1:0] r_cdb_rob;
  logic [CDB_SIZE-1:0][31:0]         r_cdb_rd_v;
  logic                              r_overflow_err;

  for (genvar i = 0; i < N_FU; i++) begin : g_fu
    assign w_in_entry[i] = {fu_rob[i], fu_data[i]};
    assign fu_stall[i]   = (w_count[i] >= CW'(FIFO_DEPTH - 1));
    assign w_deq[i]      = w_grant[i] & ~w_empty[i];
`ifdef CDB_ARB_BYPASS_EN
    // A bypassed result went straight to a lane and is not stored.
    assign w_enq[i]      = fu_valid[i] & ~flush & ~(w_grant[i] & w_empty[i]);
`else
    assign w_enq[i]      = fu_valid[i] & ~flush;
`endif
    assign w_ovf[i]      = w_enq[i] & w_full[i] & ~w_deq[i];

    cdb_fu_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .enq      (w_enq[i]),
      .enq_data (w_in_entry[i]),
      .deq      (w_deq[i]),
      .head     (w_head[i]),
      .empty    (w_empty[i]),
      .count    (w_count[i]),
      .full     (w_full[i])
    );
  end

  // Round-robin scan from r_rr_ptr; lane k takes the k-th candidate found.
  always_comb begin
    int  n;
    int  idx;
    logic cand;
    n        = 0;
    idx      = 0;
    cand     = 1'b0;
    w_grant  = '0;
    w_lane_v = '0;
    w_any    = 1'b0;
    w_last   = '0;
    for (int k = 0; k < CDB_SIZE; k++) w_lane_e[k] = '0;
    for (int k = 0; k < N_FU; k++) begin
      idx  = (int'(r_rr_ptr) + k) % N_FU;
`ifdef CDB_ARB_BYPASS_EN
      cand = ~w_empty[idx] | fu_valid[idx];
`else
      cand = ~w_empty[idx];
`endif
      if (cand && n < CDB_SIZE) begin
        w_grant[idx] = 1'b1;
        w_lane_v[n]  = 1'b1;
        w_lane_e[n]  = w_empty[idx] ? w_in_entry[idx] : w_head[idx];
        w_last       = PW'(idx);
        w_any        = 1'b1;
        n            = n + 1;
      end
    end
  end

  // Broadcast register, round-robin pointer and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr       <= '0;
      r_cdb_valid    <= '0;
      r_cdb_rob      <= '0;
      r_cdb_rd_v     <= '0;
      r_overflow_err <= 1'b0;
    end else if (flush) begin
      r_cdb_valid    <= '0;
      r_cdb_rob      <= '0;
      r_cdb_rd_v     <= '0;
    end else begin
      for (int k = 0; k < CDB_SIZE; k++) begin
        r_cdb_valid[k] <= w_lane_v[k];
        r_cdb_rob[k]   <= w_lane_e[k][EW-1:32];
        r_cdb_rd_v[k]  <= w_lane_e[k][31:0];
      end
      if (w_any) r_rr_ptr <= PW'(wrap_inc(int'(w_last), N_FU));
      if (|w_ovf) r_overflow_err <= 1'b1;
    end
  end

  assign cdb_valid    = r_cdb_valid;
  assign cdb_rob      = r_cdb_rob;
  assign cdb_rd_v     = r_cdb_rd_v;
  assign overflow_err = r_overflow_err;

  // A dropped result is worth a visible note in simulation.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(|w_ovf))
    else $warning("cdb_arbiter: result dropped at full FIFO");

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the arbiter's rules.
module tb_cdb_arbiter;

  localparam int N_FU       = 3;
  localparam int CDB_SIZE   = 2;
  localparam int ROB_DEPTH  = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int EW         = ROB_DEPTH + 32;

  logic                                clk = 1'b0;
  logic                                rst;
  logic                                flush;
  logic [N_FU-1:0]                     fu_valid;
  logic [N_FU-1:0][ROB_DEPTH-1:0]      fu_rob;
  logic [N_FU-1:0][31:0]               fu_data;
  logic [N_FU-1:0]                     fu_stall;
  logic [CDB_SIZE-1:0]                 cdb_valid;
  logic [CDB_SIZE-1:0][ROB_DEPTH-1:0]  cdb_rob;
  logic [CDB_SIZE-1:0][31:0]           cdb_rd_v;
  logic                                overflow_err;

  cdb_arbiter #(
    .N_FU       (N_FU),
    .CDB_SIZE   (CDB_SIZE),
    .ROB_DEPTH  (ROB_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fu_valid     (fu_valid),
    .fu_rob       (fu_rob),
    .fu_data      (fu_data),
    .fu_stall     (fu_stall),
    .cdb_valid    (cdb_valid),
    .cdb_rob      (cdb_rob),
    .cdb_rd_v     (cdb_rd_v),
    .overflow_err (overflow_err)
  );

  // Clock
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  logic [EW-1:0] fifo_q [N_FU][$];
  logic [EW-1:0] exp_q[$];
  int            m_rr  = 0;
  logic          m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_FU; i++) fifo_q[i].delete();
    exp_q.delete();
    m_rr  = 0;
    m_ovf = 1'b0;
  endtask

  // Apply this cycle's inputs to the model; exp_q holds the lanes the DUT
  // should present after the coming edge.
  task automatic model_step();
    bit taken [N_FU];
    int last;
    exp_q.delete();
    if (flush) begin
      for (int i = 0; i < N_FU; i++) fifo_q[i].delete();
      return;
    end
    last = -1;
    for (int i = 0; i < N_FU; i++) taken[i] = 1'b0;
    for (int k = 0; k < N_FU; k++) begin
      int i;
      i = (m_rr + k) % N_FU;
      if (exp_q.size() < CDB_SIZE) begin
        if (fifo_q[i].size() > 0) begin
          exp_q.push_back(fifo_q[i].pop_front());
          last = i;
        end
`ifdef CDB_ARB_BYPASS_EN
        else if (fu_valid[i]) begin
          exp_q.push_back({fu_rob[i], fu_data[i]});
          taken[i] = 1'b1;
          last = i;
        end
`endif
      end
    end
    if (last >= 0) m_rr = (last + 1) % N_FU;
    for (int i = 0; i < N_FU; i++) begin
      if (fu_valid[i] && !taken[i]) begin
        if (fifo_q[i].size() < FIFO_DEPTH) fifo_q[i].push_back({fu_rob[i], fu_data[i]});
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < CDB_SIZE; k++) begin
      logic [EW-1:0] e;
      logic          v;
      v = (k < exp_q.size());
      e = v ? exp_q[k] : '0;
      check($sformatf("lane%0d_valid", k), 32'(cdb_valid[k]), 32'(v));
      check($sformatf("lane%0d_rob", k), 32'(cdb_rob[k]), 32'(e[EW-1:32]));
      check($sformatf("lane%0d_data", k), cdb_rd_v[k], e[31:0]);
    end
    for (int i = 0; i < N_FU; i++)
      check($sformatf("stall%0d", i), 32'(fu_stall[i]), 32'(fifo_q[i].size() >= FIFO_DEPTH - 1));
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));
  endtask

  // Driver: one cycle of FU pulses (and optional flush), then check.
  task automatic step(input logic [N_FU-1:0] v, input logic fl, input bit rand_pl);
    fu_valid = v;
    flush    = fl;
    if (rand_pl) begin
      for (int i = 0; i < N_FU; i++) begin
        fu_rob[i]  = ROB_DEPTH'($urandom_range(0, (1 << ROB_DEPTH) - 1));
        fu_data[i] = $urandom;
      end
    end
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    fu_valid = '0;
    flush    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(cdb_valid), 32'h0);
    check({tag, "_rob"}, 32'(cdb_rob), 32'h0);
    check({tag, "_data0"}, cdb_rd_v[0], 32'h0);
    check({tag, "_data1"}, cdb_rd_v[1], 32'h0);
    check({tag, "_stall"}, 32'(fu_stall), 32'h0);
    check({tag, "_ovf"}, 32'(overflow_err), 32'h0);
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    fu_valid = '0;
    fu_rob   = '0;
    fu_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single result on FU1
    fu_rob[1]  = 3'd5;
    fu_data[1] = 32'h0000_00A4;
    step(3'b010, 1'b0, 1'b0);
`ifdef CDB_ARB_BYPASS_EN
    check("single_v", 32'(cdb_valid), 32'b01);
    check("single_rob", 32'(cdb_rob[0]), 32'd5);
    check("single_data", cdb_rd_v[0], 32'hA4);
`endif
    step(3'b000, 1'b0, 1'b1);
`ifndef CDB_ARB_BYPASS_EN
    check("single_v", 32'(cdb_valid), 32'b01);
    check("single_rob", 32'(cdb_rob[0]), 32'd5);
    check("single_data", cdb_rd_v[0], 32'hA4);
`endif
    repeat (2) step(3'b000, 1'b0, 1'b1);

    // All three FUs in one cycle
    step(3'b111, 1'b0, 1'b1);
    repeat (3) step(3'b000, 1'b0, 1'b1);

    // Fairness: FU0 and FU2 streaming, FU1 idle
    repeat (4) step(3'b101, 1'b0, 1'b1);
    repeat (5) step(3'b000, 1'b0, 1'b1);

    // Saturate all FIFOs so FU1 stalls and eventually overflows
    repeat (20) step(3'b111, 1'b0, 1'b1);
    check("ovf_directed", 32'(overflow_err), 32'h1);
    check("stall1_directed", 32'(fu_stall[1]), 32'h1);

    // Flush with buffered entries and a same-cycle pulse
    step(3'b111, 1'b1, 1'b1);
    check("flush_valid", 32'(cdb_valid), 32'h0);
    check("flush_stall", 32'(fu_stall), 32'h0);
    repeat (2) step(3'b000, 1'b0, 1'b1);

    // Random traffic with occasional flush
    for (int c = 0; c < 400; c++) begin
      logic [N_FU-1:0] v;
      v = N_FU'($urandom_range(0, 7));
      step(v, ($urandom_range(0, 19) == 0), 1'b1);
    end

    // Async reset mid-cycle with full FIFOs
    repeat (20) step(3'b111, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      logic [N_FU-1:0] v;
      v = N_FU'($urandom_range(0, 7));
      step(v, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
